// File: rtl/riscv_pkg.sv
// Shared decode definitions: control bundle layout, ALU and result-select
// encodings, and the hard-wired zero register index.
package riscv_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   localparam logic [1:0] RESULT_ALU = 2'd0;
   localparam logic [1:0] RESULT_MEM = 2'd1;
   localparam logic [1:0] RESULT_PC4 = 2'd2;
   localparam logic [1:0] RESULT_IMM = 2'd3;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic [1:0] result_src;
      logic       branch;
      logic       jump;
      logic [3:0] alu_ctrl;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use check: a load sitting in the execute slot whose
// destination is read by the instruction decode is offering right now.
module load_use_detect
   import riscv_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              i_ex_valid,
   input  logic              i_ex_mem_read,
   input  logic [REG_AW-1:0] i_ex_rd,
   input  logic              i_id_valid,
   input  logic [REG_AW-1:0] i_id_rs1,
   input  logic [REG_AW-1:0] i_id_rs2,
   input  logic              i_id_use_rs1,
   input  logic              i_id_use_rs2,
   output logic              o_hazard
);

   logic w_rd_live;
   logic w_rs1_hit;
   logic w_rs2_hit;

   // x0 is never really written, so a load into it cannot create a dependency
   assign w_rd_live = i_ex_valid & i_ex_mem_read & (i_ex_rd != REG_AW'(REG_ZERO));
   assign w_rs1_hit = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
   assign w_rs2_hit = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
   assign o_hazard  = w_rd_live & i_id_valid & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion and flush.
// Define ID_EX_STAT_EN to build the stall/flush event counters.
module id_ex_pipe
   import riscv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_rd1,
   input  logic [XLEN-1:0]   in_rd2,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [REG_AW-1:0] in_rs1,
   input  logic [REG_AW-1:0] in_rs2,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_use_rs1,
   input  logic              in_use_rs2,
   input  ctrl_t             in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_rd1,
   output logic [XLEN-1:0]   out_rd2,
   output logic [XLEN-1:0]   out_imm,
   output logic [REG_AW-1:0] out_rs1,
   output logic [REG_AW-1:0] out_rs2,
   output logic [REG_AW-1:0] out_rd,
   output ctrl_t             out_ctrl,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);

   logic              r_valid;
   logic [XLEN-1:0]   r_pc, r_rd1, r_rd2, r_imm;
   logic [REG_AW-1:0] r_rs1, r_rs2, r_rd;
   ctrl_t             r_ctrl;

   logic w_hazard;
   logic w_accept;
   logic w_drain;

   load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
      .i_ex_valid    (r_valid),
      .i_ex_mem_read (r_ctrl.mem_read),
      .i_ex_rd       (r_rd),
      .i_id_valid    (in_valid),
      .i_id_rs1      (in_rs1),
      .i_id_rs2      (in_rs2),
      .i_id_use_rs1  (in_use_rs1),
      .i_id_use_rs2  (in_use_rs2),
      .o_hazard      (w_hazard)
   );

   // During a flush decode's offer is swallowed, hence ready regardless of slot state
   assign in_ready = flush | ((~r_valid | out_ready) & ~w_hazard);
   assign w_accept = in_valid & in_ready;
   assign w_drain  = r_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_imm   <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_rd    <= '0;
         r_ctrl  <= CTRL_NOP;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_hazard & out_ready) begin
         r_valid <= 1'b0;
         r_ctrl  <= CTRL_NOP;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_pc    <= in_pc;
         r_rd1   <= in_rd1;
         r_rd2   <= in_rd2;
         r_imm   <= in_imm;
         r_rs1   <= in_rs1;
         r_rs2   <= in_rs2;
         r_rd    <= in_rd;
         r_ctrl  <= in_ctrl;
      end else if (w_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid = r_valid;
   assign out_pc    = r_pc;
   assign out_rd1   = r_rd1;
   assign out_rd2   = r_rd2;
   assign out_imm   = r_imm;
   assign out_rs1   = r_rs1;
   assign out_rs2   = r_rs2;
   assign out_rd    = r_rd;
   assign out_ctrl  = r_ctrl;

`ifdef ID_EX_STAT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_hazard & out_ready & ~flush) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (flush)                         r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
